// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the pipeline-side signals exchanged with the hazard controller:
//   - ID/EX hazard information (register indices, load/branch/JALR flags)
//   - data-cache miss handshake (dmiss_req level, dmiss_done pulse)
//   - bubble (hold) / flush (clear) controls for the IF, ID/EX, EX/MEM and
//     MEM/WB segment registers
// Modports:
//   master : the pipeline datapath (drives hazard info, receives controls)
//   slave  : the hazard controller (receives hazard info, drives controls)
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0] reg1_srcD;
  logic [4:0] reg2_srcD;
  logic [4:0] reg_dstE;
  logic       mem_rdE;
  logic       br_instE;
  logic       br_takenE;
  logic       predict_brE;
  logic       jalrE;
  logic       dmiss_req;
  logic       dmiss_done;
  logic       bubbleF;
  logic       flushF;
  logic       bubbleD;
  logic       flushD;
  logic       bubbleE;
  logic       flushE;
  logic       bubbleM;
  logic       flushM;
  logic       bubbleW;
  logic       flushW;

  modport master (
    output reg1_srcD, reg2_srcD, reg_dstE, mem_rdE, br_instE, br_takenE,
           predict_brE, jalrE, dmiss_req, dmiss_done,
    input  bubbleF, flushF, bubbleD, flushD, bubbleE, flushE,
           bubbleM, flushM, bubbleW, flushW
  );

  modport slave (
    input  reg1_srcD, reg2_srcD, reg_dstE, mem_rdE, br_instE, br_takenE,
           predict_brE, jalrE, dmiss_req, dmiss_done,
    output bubbleF, flushF, bubbleD, flushD, bubbleE, flushE,
           bubbleM, flushM, bubbleW, flushW
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a 5-stage RV32I pipeline. It resolves
// data-cache miss stalls, branch mispredict / JALR redirects and load-use
// hazards (in that priority) and keeps saturating performance counters.
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   clr_cnt     : synchronous clear of all performance counters
//   hz          : hazard info in, segment-register bubble/flush out
//   br_cnt      : branches that left EX
//   mispred_cnt : mispredicted branches plus JALR redirects that left EX
//   stall_cnt   : cycles with bubbleF asserted
// Controls are combinational in the state and current inputs so the
// pipeline reacts in the same cycle the hazard is visible.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_cnt,
  pipe_hazard_ctrl_if.slave   hz,
  output logic [CNT_W-1:0]    br_cnt,
  output logic [CNT_W-1:0]    mispred_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MISS    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             miss_stall_s;
  logic             mispred_s;
  logic             loaduse_s;
  logic [9:0]       ctrl_s;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] mispred_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Miss sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a done pulse is only honoured once the FSM is already in
  // MISS, so a done coincident with a new request is dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (hz.dmiss_req) begin
          state_nxt_s = MISS;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MISS: begin
        if (hz.dmiss_done) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = MISS;
        end
      end
      RELEASE: state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Hazard classification. RELEASE ignores dmiss_req so refilled MEM data
  // can settle; during a miss stall EX is frozen, so mispredict and
  // load-use are re-evaluated once the stall ends.
  always_comb begin
    miss_stall_s = ((state_r == RUN) && hz.dmiss_req) || (state_r == MISS);
    mispred_s    = !miss_stall_s &&
                   ((hz.br_instE && (hz.br_takenE != hz.predict_brE)) || hz.jalrE);
    loaduse_s    = !miss_stall_s && !mispred_s && hz.mem_rdE &&
                   (hz.reg_dstE != 5'd0) &&
                   ((hz.reg_dstE == hz.reg1_srcD) || (hz.reg_dstE == hz.reg2_srcD));
  end

  // Control vector {bF,fF,bD,fD,bE,fE,bM,fM,bW,fW}; all zero while in reset.
  always_comb begin
    ctrl_s = 10'b00_0000_0000;
    if (!rst_n) begin
      ctrl_s = 10'b00_0000_0000;
    end else if (miss_stall_s) begin
      ctrl_s = 10'b10_1010_1001;
    end else if (mispred_s) begin
      ctrl_s = 10'b00_0101_0000;
    end else if (loaduse_s) begin
      ctrl_s = 10'b10_1001_0000;
    end else begin
      ctrl_s = 10'b00_0000_0000;
    end
  end

  assign hz.bubbleF = ctrl_s[9];
  assign hz.flushF  = ctrl_s[8];
  assign hz.bubbleD = ctrl_s[7];
  assign hz.flushD  = ctrl_s[6];
  assign hz.bubbleE = ctrl_s[5];
  assign hz.flushE  = ctrl_s[4];
  assign hz.bubbleM = ctrl_s[3];
  assign hz.flushM  = ctrl_s[2];
  assign hz.bubbleW = ctrl_s[1];
  assign hz.flushW  = ctrl_s[0];

  // Performance counters: branch/mispredict counts only when EX advances
  // (bubbleE low); clear wins over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r      <= {CNT_W{1'b0}};
      mispred_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      br_cnt_r      <= {CNT_W{1'b0}};
      mispred_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      br_cnt_r      <= sat_inc(br_cnt_r, !ctrl_s[5] && hz.br_instE);
      mispred_cnt_r <= sat_inc(mispred_cnt_r, !ctrl_s[5] && mispred_s);
      stall_cnt_r   <= sat_inc(stall_cnt_r, ctrl_s[9]);
    end
  end

  assign br_cnt      = br_cnt_r;
  assign mispred_cnt = mispred_cnt_r;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (CNT_W = 4 so saturation is reachable).
// Inputs change on the falling edge; controls are sampled 1 time unit later
// and counters are sampled on the following falling edge.
// Control vector order: {bF,fF,bD,fD,bE,fE,bM,fM,bW,fW}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam logic [9:0] O_NONE = 10'b00_0000_0000;
  localparam logic [9:0] O_MISS = 10'b10_1010_1001;
  localparam logic [9:0] O_MP   = 10'b00_0101_0000;
  localparam logic [9:0] O_LU   = 10'b10_1001_0000;

  logic          clk;
  logic          rst_n;
  logic          clr_cnt;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mispred_cnt;
  logic [CW-1:0] stall_cnt;
  int            total;
  int            bad;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_cnt     (clr_cnt),
    .hz          (hz.slave),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {hz.bubbleF, hz.flushF, hz.bubbleD, hz.flushD, hz.bubbleE,
            hz.flushE, hz.bubbleM, hz.flushM, hz.bubbleW, hz.flushW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] eb,
                         input logic [CW-1:0] em, input logic [CW-1:0] es);
    chk({tag, "_br"}, {28'd0, br_cnt}, {28'd0, eb});
    chk({tag, "_mp"}, {28'd0, mispred_cnt}, {28'd0, em});
    chk({tag, "_st"}, {28'd0, stall_cnt}, {28'd0, es});
  endtask

  task automatic idle_inputs();
    hz.reg1_srcD   = 5'd0;
    hz.reg2_srcD   = 5'd0;
    hz.reg_dstE    = 5'd0;
    hz.mem_rdE     = 1'b0;
    hz.br_instE    = 1'b0;
    hz.br_takenE   = 1'b0;
    hz.predict_brE = 1'b0;
    hz.jalrE       = 1'b0;
    hz.dmiss_req   = 1'b0;
    hz.dmiss_done  = 1'b0;
    clr_cnt        = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset: outputs held low even with a miss and load-use presented.
    hz.dmiss_req = 1'b1;
    hz.mem_rdE   = 1'b1;
    hz.reg_dstE  = 5'd5;
    hz.reg1_srcD = 5'd5;
    #2;
    chk("rst_outs", {22'd0, outs()}, {22'd0, O_NONE});
    chk_cnt("rst", 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1 chk("idle_outs", {22'd0, outs()}, {22'd0, O_NONE});

    // Load-use on rs1, then the bubble in EX releases the stall.
    @(negedge clk);
    hz.mem_rdE = 1'b1; hz.reg_dstE = 5'd5; hz.reg1_srcD = 5'd5;
    #1 chk("lu_rs1", {22'd0, outs()}, {22'd0, O_LU});
    @(negedge clk);
    hz.mem_rdE = 1'b0;
    #1 chk("lu_release", {22'd0, outs()}, {22'd0, O_NONE});
    chk_cnt("lu", 4'd0, 4'd0, 4'd1);

    // Load into x0 never stalls; then load-use on rs2.
    @(negedge clk);
    hz.mem_rdE = 1'b1; hz.reg_dstE = 5'd0; hz.reg1_srcD = 5'd0; hz.reg2_srcD = 5'd0;
    #1 chk("x0_load", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    hz.reg_dstE = 5'd7; hz.reg1_srcD = 5'd3; hz.reg2_srcD = 5'd7;
    #1 chk("lu_rs2", {22'd0, outs()}, {22'd0, O_LU});
    @(negedge clk);
    chk_cnt("x0", 4'd0, 4'd0, 4'd2);
    idle_inputs();

    // Mispredict (taken, predicted not-taken).
    hz.br_instE = 1'b1; hz.br_takenE = 1'b1; hz.predict_brE = 1'b0;
    #1 chk("mp_taken", {22'd0, outs()}, {22'd0, O_MP});
    @(negedge clk);
    chk_cnt("mp1", 4'd1, 4'd1, 4'd2);
    // Correct prediction.
    hz.predict_brE = 1'b1;
    #1 chk("br_ok", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    chk_cnt("brok", 4'd2, 4'd1, 4'd2);
    // JALR redirect without a branch.
    idle_inputs();
    hz.jalrE = 1'b1;
    #1 chk("jalr", {22'd0, outs()}, {22'd0, O_MP});
    @(negedge clk);
    chk_cnt("jalr", 4'd2, 4'd2, 4'd2);
    // Mispredict (not-taken vs predicted taken) outranks a load-use.
    idle_inputs();
    hz.br_instE = 1'b1; hz.br_takenE = 1'b0; hz.predict_brE = 1'b1;
    hz.mem_rdE = 1'b1; hz.reg_dstE = 5'd5; hz.reg1_srcD = 5'd5;
    #1 chk("mp_over_lu", {22'd0, outs()}, {22'd0, O_MP});
    @(negedge clk);
    chk_cnt("mplu", 4'd3, 4'd3, 4'd2);

    // Counter clear.
    idle_inputs();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk_cnt("clr", 4'd0, 4'd0, 4'd0);

    // Miss for 4 cycles with a concurrent mispredict; done on the 4th.
    hz.dmiss_req = 1'b1;
    hz.br_instE = 1'b1; hz.br_takenE = 1'b1; hz.predict_brE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) hz.dmiss_done = 1'b1;
      #1 chk("miss_cyc", {22'd0, outs()}, {22'd0, O_MISS});
      @(negedge clk);
    end
    chk_cnt("miss4", 4'd0, 4'd0, 4'd4);
    hz.dmiss_req = 1'b0; hz.dmiss_done = 1'b0;
    #1 chk("release_mp", {22'd0, outs()}, {22'd0, O_MP});
    @(negedge clk);
    chk_cnt("release", 4'd1, 4'd1, 4'd4);
    idle_inputs();
    #1 chk("post_miss", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    chk_cnt("postmiss", 4'd1, 4'd1, 4'd4);

    // Request and done together in RUN: done dropped, still MISS after.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    hz.dmiss_req = 1'b1; hz.dmiss_done = 1'b1;
    #1 chk("req_done_run", {22'd0, outs()}, {22'd0, O_MISS});
    @(negedge clk);
    hz.dmiss_done = 1'b0;
    #1 chk("still_miss", {22'd0, outs()}, {22'd0, O_MISS});
    @(negedge clk);
    hz.dmiss_done = 1'b1;
    #1 chk("miss_done", {22'd0, outs()}, {22'd0, O_MISS});
    @(negedge clk);
    hz.dmiss_done = 1'b0;
    #1 chk("release_no_det", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    #1 chk("rerun_miss", {22'd0, outs()}, {22'd0, O_MISS});
    @(negedge clk);
    hz.dmiss_req = 1'b0; hz.dmiss_done = 1'b1;
    #1 chk("miss_done2", {22'd0, outs()}, {22'd0, O_MISS});
    @(negedge clk);
    hz.dmiss_done = 1'b0;
    #1 chk("release2", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    chk_cnt("reqdone", 4'd0, 4'd0, 4'd5);

    // Reset asserted while in MISS; stray done afterwards is ignored.
    hz.dmiss_req = 1'b1;
    @(negedge clk);
    #1 chk("miss_pre_rst", {22'd0, outs()}, {22'd0, O_MISS});
    rst_n = 1'b0;
    #1 chk("rst_mid_miss", {22'd0, outs()}, {22'd0, O_NONE});
    chk_cnt("rstmid", 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hz.dmiss_req = 1'b0; hz.dmiss_done = 1'b1;
    #1 chk("stray_done", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    hz.dmiss_done = 1'b0;
    #1 chk("after_stray", {22'd0, outs()}, {22'd0, O_NONE});
    @(negedge clk);
    chk_cnt("stray", 4'd0, 4'd0, 4'd0);

    // Saturation: 20 correctly predicted branches into a 4-bit counter.
    hz.br_instE = 1'b1; hz.br_takenE = 1'b1; hz.predict_brE = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk_cnt("sat", 4'd15, 4'd0, 4'd0);
    // Clear with a branch in the same cycle wins.
    clr_cnt = 1'b1;
    @(negedge clk);
    chk_cnt("clr_br", 4'd0, 4'd0, 4'd0);
    clr_cnt = 1'b0;
    @(negedge clk);
    chk_cnt("after_clr", 4'd1, 4'd0, 4'd0);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
